// File: rtl/mem_io_bridge.sv
// mem_io_bridge: load/store access unit between the core's RAM/IO port and
// a synchronous RAM plus a req/ack IO bus. It decodes the request, aligns
// byte lanes, generates byte enables, runs the access, and returns the
// extended load data with a one-cycle done/err pulse.
//
// Handshakes:
//   core side: core_req is sampled only in IDLE; the result appears with a
//              one-cycle core_done pulse (core_err is qualified by core_done).
//   RAM side : ram_en is a one-cycle strobe; ram_rdat is valid the cycle after.
//   IO side  : io_req and its qualifiers stay stable until the cycle io_ack is
//              sampled high, or until the timeout expires.
module mem_io_bridge #(
    parameter int unsigned RAM_AW  = 14,
    parameter logic [31:0] IO_BASE = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_wr,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdat,
    input  logic [2:0]        core_rw_type,
    output logic [31:0]       core_rdat,
    output logic              core_done,
    output logic              core_err,
    output logic              core_busy,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdat,
    input  logic [31:0]       ram_rdat,
    output logic              io_req,
    output logic              io_wr,
    output logic [31:0]       io_addr,
    output logic [3:0]        io_be,
    output logic [31:0]       io_wdat,
    input  logic [31:0]       io_rdat,
    input  logic              io_ack
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_ACC,
        S_RAM_RSP,
        S_IO_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic              wr_q, wr_d;
    logic [2:0]        type_q, type_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       core_rdat_q, core_rdat_d;
    logic              core_done_q, core_done_d;
    logic              core_err_q, core_err_d;
    logic              core_busy_q, core_busy_d;
    logic              ram_en_q, ram_en_d;
    logic [3:0]        ram_we_q, ram_we_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdat_q, ram_wdat_d;
    logic              io_req_q, io_req_d;
    logic              io_wr_q, io_wr_d;
    logic [31:0]       io_addr_q, io_addr_d;
    logic [3:0]        io_be_q, io_be_d;
    logic [31:0]       io_wdat_q, io_wdat_d;

    logic [3:0]        req_be;
    logic [31:0]       req_wdat;
    logic              req_bad;
    logic              req_is_io;

    // Pick the addressed lane, then sign- or zero-extend by access type.
    function automatic logic [31:0] extend_load(input logic [31:0] data,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  rw_type);
        logic [31:0] shifted;
        shifted = data >> {lane, 3'b000};
        case (rw_type)
            3'b000:  extend_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  extend_load = {24'h000000, shifted[7:0]};
            3'b001:  extend_load = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  extend_load = {16'h0000, shifted[15:0]};
            default: extend_load = shifted;
        endcase
    endfunction

    // Decode the incoming request: lanes, replicated store data, legality, region.
    always_comb begin
        req_be    = 4'b1111;
        req_wdat  = core_wdat;
        req_bad   = 1'b0;
        req_is_io = (core_addr[31:12] == IO_BASE[31:12]);
        case (core_rw_type[1:0])
            2'b00: begin
                req_be   = 4'b0001 << core_addr[1:0];
                req_wdat = {4{core_wdat[7:0]}};
            end
            2'b01: begin
                req_be   = 4'b0011 << {core_addr[1], 1'b0};
                req_wdat = {2{core_wdat[15:0]}};
                req_bad  = core_addr[0];
            end
            2'b10: begin
                req_be   = 4'b1111;
                req_wdat = core_wdat;
                req_bad  = (core_addr[1:0] != 2'b00);
            end
            default: req_bad = 1'b1;
        endcase
        if (core_rw_type == 3'b110 || core_rw_type == 3'b111) begin
            req_bad = 1'b1;
        end
    end

    // Next-state and next-output computation; every bus output is registered.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        wr_d        = wr_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        core_rdat_d = core_rdat_q;
        core_done_d = 1'b0;
        core_err_d  = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 4'b0000;
        ram_addr_d  = ram_addr_q;
        ram_wdat_d  = ram_wdat_q;
        io_req_d    = io_req_q;
        io_wr_d     = io_wr_q;
        io_addr_d   = io_addr_q;
        io_be_d     = io_be_q;
        io_wdat_d   = io_wdat_q;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    lane_d = core_addr[1:0];
                    wr_d   = core_wr;
                    type_d = core_rw_type;
                    if (req_bad) begin
                        state_d     = S_DONE;
                        core_done_d = 1'b1;
                        core_err_d  = 1'b1;
                        core_rdat_d = 32'h0;
                    end else if (req_is_io) begin
                        state_d   = S_IO_WAIT;
                        cnt_d     = '0;
                        io_req_d  = 1'b1;
                        io_wr_d   = core_wr;
                        io_addr_d = core_addr;
                        io_be_d   = req_be;
                        io_wdat_d = req_wdat;
                    end else begin
                        state_d    = S_RAM_ACC;
                        ram_en_d   = 1'b1;
                        ram_we_d   = core_wr ? req_be : 4'b0000;
                        ram_addr_d = core_addr[RAM_AW+1:2];
                        ram_wdat_d = req_wdat;
                    end
                end
            end
            S_RAM_ACC: begin
                if (wr_q) begin
                    state_d     = S_DONE;
                    core_done_d = 1'b1;
                    core_rdat_d = 32'h0;
                end else begin
                    state_d = S_RAM_RSP;
                end
            end
            S_RAM_RSP: begin
                state_d     = S_DONE;
                core_done_d = 1'b1;
                core_rdat_d = extend_load(ram_rdat, lane_q, type_q);
            end
            S_IO_WAIT: begin
                // An ack on the final permitted cycle still wins over the timeout.
                if (io_ack) begin
                    state_d     = S_DONE;
                    core_done_d = 1'b1;
                    io_req_d    = 1'b0;
                    core_rdat_d = wr_q ? 32'h0 : extend_load(io_rdat, lane_q, type_q);
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                    io_req_d    = 1'b0;
                    core_rdat_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        core_busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'b00;
            wr_q        <= 1'b0;
            type_q      <= 3'b000;
            cnt_q       <= '0;
            core_rdat_q <= 32'h0;
            core_done_q <= 1'b0;
            core_err_q  <= 1'b0;
            core_busy_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_wdat_q  <= 32'h0;
            io_req_q    <= 1'b0;
            io_wr_q     <= 1'b0;
            io_addr_q   <= 32'h0;
            io_be_q     <= 4'b0000;
            io_wdat_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            wr_q        <= wr_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            core_rdat_q <= core_rdat_d;
            core_done_q <= core_done_d;
            core_err_q  <= core_err_d;
            core_busy_q <= core_busy_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdat_q  <= ram_wdat_d;
            io_req_q    <= io_req_d;
            io_wr_q     <= io_wr_d;
            io_addr_q   <= io_addr_d;
            io_be_q     <= io_be_d;
            io_wdat_q   <= io_wdat_d;
        end
    end

    assign core_rdat = core_rdat_q;
    assign core_done = core_done_q;
    assign core_err  = core_err_q;
    assign core_busy = core_busy_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdat  = ram_wdat_q;
    assign io_req    = io_req_q;
    assign io_wr     = io_wr_q;
    assign io_addr   = io_addr_q;
    assign io_be     = io_be_q;
    assign io_wdat   = io_wdat_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: vector table of RAM/IO accesses with a scoreboard queue,
// plus hand-written sequences for busy rejection and reset during an IO wait.
module tb_mem_io_bridge;

  localparam int RAM_AW  = 14;
  localparam int TIMEOUT = 255;
  localparam int BUDGET  = 400;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rst_n;
  logic              core_req;
  logic              core_wr;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdat;
  logic [2:0]        core_rw_type;
  logic [31:0]       core_rdat;
  logic              core_done;
  logic              core_err;
  logic              core_busy;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdat;
  logic [31:0]       ram_rdat;
  logic              io_req;
  logic              io_wr;
  logic [31:0]       io_addr;
  logic [3:0]        io_be;
  logic [31:0]       io_wdat;
  logic [31:0]       io_rdat;
  logic              io_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_io_bridge #(
    .RAM_AW  (RAM_AW),
    .IO_BASE (32'hFFFF_F000),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_req     (core_req),
    .core_wr      (core_wr),
    .core_addr    (core_addr),
    .core_wdat    (core_wdat),
    .core_rw_type (core_rw_type),
    .core_rdat    (core_rdat),
    .core_done    (core_done),
    .core_err     (core_err),
    .core_busy    (core_busy),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdat     (ram_wdat),
    .ram_rdat     (ram_rdat),
    .io_req       (io_req),
    .io_wr        (io_wr),
    .io_addr      (io_addr),
    .io_be        (io_be),
    .io_wdat      (io_wdat),
    .io_rdat      (io_rdat),
    .io_ack       (io_ack)
  );

  // ---------------- synchronous RAM model ----------------
  logic [31:0] mem [0:(1<<RAM_AW)-1];

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdat <= mem[ram_addr];
      if (ram_we[0]) mem[ram_addr][7:0]   <= ram_wdat[7:0];
      if (ram_we[1]) mem[ram_addr][15:8]  <= ram_wdat[15:8];
      if (ram_we[2]) mem[ram_addr][23:16] <= ram_wdat[23:16];
      if (ram_we[3]) mem[ram_addr][31:24] <= ram_wdat[31:24];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;
  // {check_rdat, err, rdat}
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [2:0]  typ;
    int          ack_dly;
    logic [31:0] io_rd;
    logic [31:0] exp_rdat;
    logic        exp_err;
    logic        chk_rdat;
    int          exp_lat;
    int          exp_ram;
    int          exp_io;
    logic [13:0] exp_ra;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdat;
    logic        hold;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] wdat, logic [2:0] typ,
                              int ack_dly, logic [31:0] io_rd, logic [31:0] exp_rdat,
                              logic exp_err, int exp_lat, int exp_ram, int exp_io,
                              logic [13:0] ra, logic [3:0] be, logic [31:0] ewd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdat = wdat; v.typ = typ;
    v.ack_dly = ack_dly; v.io_rd = io_rd;
    v.exp_rdat = exp_rdat; v.exp_err = exp_err; v.chk_rdat = !wr || exp_err;
    v.exp_lat = exp_lat; v.exp_ram = exp_ram; v.exp_io = exp_io;
    v.exp_ra = ra; v.exp_be = be; v.exp_wdat = ewd; v.hold = 1'b0;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Starts at a negedge with the DUT idle; ends at the negedge after done.
  task automatic run_txn(input string tag, input vec_t v);
    int          cyc;
    int          ram_cnt;
    int          io_cnt;
    int          busy_bad;
    int          io_unstable;
    bit          got_done;
    logic [33:0] e;
    core_req     = 1'b1;
    core_wr      = v.wr;
    core_addr    = v.addr;
    core_wdat    = v.wdat;
    core_rw_type = v.typ;
    exp_q.push_back({v.chk_rdat, v.exp_err, v.exp_rdat});
    @(posedge clk);
    cyc = 0; ram_cnt = 0; io_cnt = 0; busy_bad = 0; io_unstable = 0; got_done = 0;
    while (!got_done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (!v.hold) core_req = 1'b0;
      io_ack = 1'b0;
      if (!core_busy) busy_bad++;
      if (ram_en) begin
        ram_cnt++;
        check({tag, " ram_addr"}, 32'(ram_addr), 32'(v.exp_ra));
        check({tag, " ram_we"}, 32'(ram_we), v.wr ? 32'(v.exp_be) : 32'h0);
        if (v.wr) check({tag, " ram_wdat"}, ram_wdat, v.exp_wdat);
      end
      if (io_req) begin
        io_cnt++;
        if (io_cnt == 1) begin
          check({tag, " io_addr"}, io_addr, v.addr);
          check({tag, " io_wr"}, 32'(io_wr), 32'(v.wr));
          check({tag, " io_be"}, 32'(io_be), 32'(v.exp_be));
          if (v.wr) check({tag, " io_wdat"}, io_wdat, v.exp_wdat);
        end else if (io_addr !== v.addr || io_be !== v.exp_be || io_wr !== v.wr) begin
          io_unstable++;
        end
        if (io_cnt == v.ack_dly) begin
          io_ack  = 1'b1;
          io_rdat = v.io_rd;
        end
      end
      if (core_done) begin
        got_done = 1;
        check({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
        if (exp_q.size() == 0) begin
          check({tag, " scoreboard empty"}, 32'h0, 32'h1);
        end else begin
          e = exp_q.pop_front();
          check({tag, " err"}, 32'(core_err), 32'(e[32]));
          if (e[33]) check({tag, " rdat"}, core_rdat, e[31:0]);
        end
      end
    end
    io_ack = 1'b0;
    if (!got_done) check({tag, " done timeout"}, 32'(cyc), 32'(v.exp_lat));
    check({tag, " ram_en cycles"}, 32'(ram_cnt), 32'(v.exp_ram));
    check({tag, " io_req cycles"}, 32'(io_cnt), 32'(v.exp_io));
    check({tag, " busy while active"}, 32'(busy_bad), 32'h0);
    if (v.exp_io > 0) check({tag, " io stable"}, 32'(io_unstable), 32'h0);
    @(negedge clk);
    check({tag, " idle after done"}, {30'h0, core_busy, core_done}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " core_rdat"}, core_rdat, 32'h0);
    check({tag, " ctl"}, {25'h0, core_done, core_err, core_busy, ram_en, io_req, io_wr, 1'b0}, 32'h0);
    check({tag, " ram_we/io_be"}, {24'h0, ram_we, io_be}, 32'h0);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'h0);
    check({tag, " ram_wdat"}, ram_wdat, 32'h0);
    check({tag, " io_addr"}, io_addr, 32'h0);
    check({tag, " io_wdat"}, io_wdat, 32'h0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[30];
  vec_t v;
  int   req_hi;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = mk(1, 'h10, 'hDEADBEEF, T_W, 0, 0, 0, 0, 2, 1, 0, 'h4, 'hF, 'hDEADBEEF);
    vecs[1]  = mk(0, 'h10, 0, T_W, 0, 0, 'hDEADBEEF, 0, 3, 1, 0, 'h4, 'hF, 0);
    vecs[2]  = mk(1, 'h13, 'h55555580, T_B, 0, 0, 0, 0, 2, 1, 0, 'h4, 'h8, 'h80808080);
    vecs[3]  = mk(0, 'h13, 0, T_B, 0, 0, 'hFFFFFF80, 0, 3, 1, 0, 'h4, 'h8, 0);
    vecs[4]  = mk(0, 'h13, 0, T_BU, 0, 0, 'h00000080, 0, 3, 1, 0, 'h4, 'h8, 0);
    vecs[5]  = mk(0, 'h12, 0, T_H, 0, 0, 'hFFFF80AD, 0, 3, 1, 0, 'h4, 'hC, 0);
    vecs[6]  = mk(0, 'h10, 0, T_HU, 0, 0, 'h0000BEEF, 0, 3, 1, 0, 'h4, 'h3, 0);
    vecs[7]  = mk(0, 'h10, 0, T_H, 0, 0, 'hFFFFBEEF, 0, 3, 1, 0, 'h4, 'h3, 0);
    vecs[8]  = mk(0, 'h11, 0, T_B, 0, 0, 'hFFFFFFBE, 0, 3, 1, 0, 'h4, 'h2, 0);
    vecs[9]  = mk(1, 'h20, 0, T_W, 0, 0, 0, 0, 2, 1, 0, 'h8, 'hF, 0);
    vecs[10] = mk(1, 'h22, 'hAAAA1234, T_H, 0, 0, 0, 0, 2, 1, 0, 'h8, 'hC, 'h12341234);
    vecs[11] = mk(0, 'h22, 0, T_HU, 0, 0, 'h00001234, 0, 3, 1, 0, 'h8, 'hC, 0);
    vecs[12] = mk(0, 'h20, 0, T_W, 0, 0, 'h12340000, 0, 3, 1, 0, 'h8, 'hF, 0);
    vecs[13] = mk(0, 'h21, 0, T_H, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 'h22, 'h1, T_W, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 'h30, 0, 3'b011, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 'h30, 0, 3'b110, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 'h30, 0, 3'b111, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 'h23, 0, T_HU, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 'hFFFFF006, 'hFFFF1234, T_H, 3, 0, 0, 0, 4, 0, 3, 0, 'hC, 'h12341234);
    vecs[20] = mk(0, 'hFFFFF001, 0, T_B, 1, 'h0000F700, 'hFFFFFFF7, 0, 2, 0, 1, 0, 'h2, 0);
    vecs[21] = mk(0, 'hFFFFF002, 0, T_HU, 5, 'h80010000, 'h00008001, 0, 6, 0, 5, 0, 'hC, 0);
    vecs[22] = mk(0, 'hFFFFF000, 0, T_W, 0, 'h0, 0, 1, TIMEOUT + 1, 0, TIMEOUT, 0, 'hF, 0);
    vecs[23] = mk(0, 'hFFFFF00C, 0, T_W, TIMEOUT, 'h13579BDF, 'h13579BDF, 0, TIMEOUT + 1, 0, TIMEOUT, 0, 'hF, 0);
    vecs[24] = mk(1, 'h00040040, 'hCAFEF00D, T_W, 0, 0, 0, 0, 2, 1, 0, 'h10, 'hF, 'hCAFEF00D);
    vecs[25] = mk(0, 'h40, 0, T_W, 0, 0, 'hCAFEF00D, 0, 3, 1, 0, 'h10, 'hF, 0);
    vecs[26] = mk(1, 'hFFFFE000, 'h0BADF00D, T_W, 0, 0, 0, 0, 2, 1, 0, 'h3800, 'hF, 'h0BADF00D);
    vecs[27] = mk(0, 'hFFFFE003, 0, T_BU, 0, 0, 'h0000000B, 0, 3, 1, 0, 'h3800, 'h8, 0);
    vecs[28] = mk(0, 'hFFFFF002, 0, T_W, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[29] = mk(0, 'hFFFFF004, 0, T_H, 2, 'h00008123, 'hFFFF8123, 0, 3, 0, 2, 0, 'h3, 0);

    // clock/reset
    rst_n = 1'b0; core_req = 1'b0; core_wr = 1'b0; core_addr = 32'h0;
    core_wdat = 32'h0; core_rw_type = 3'b000; io_rdat = 32'h0; io_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post-reset idle");

    // table-driven vectors
    for (int i = 0; i < 30; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // core_req held high across a RAM load: one access, next accepted right after
    v = mk(0, 'h20, 0, T_W, 0, 0, 'h12340000, 0, 3, 1, 0, 'h8, 'hF, 0);
    v.hold = 1'b1;
    run_txn("busy-hold", v);
    v.hold = 1'b0;
    run_txn("busy-next", v);

    // reset while waiting on IO: io_req and busy drop at once, no done pulse
    core_req = 1'b1; core_wr = 1'b0; core_addr = 32'hFFFFF000; core_rw_type = T_W;
    @(posedge clk);
    req_hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      core_req = 1'b0;
      if (io_req && core_busy && !core_done) req_hi++;
    end
    check("rst-wait io_req held", 32'(req_hi), 32'd10);
    #1 rst_n = 1'b0;
    #1 check("rst-wait io_req/busy cleared", {30'h0, io_req, core_busy}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst-wait no done", {30'h0, core_done, io_req}, 32'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst-release idle", {29'h0, core_done, io_req, core_busy}, 32'h0);
    end
    run_txn("after-reset", mk(0, 'h10, 0, T_W, 0, 0, 'h80ADBEEF, 0, 3, 1, 0, 'h4, 'hF, 0));

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
